// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel path: pixel width, 3x3 window geometry and
// the byte position of each window element in the packed 72-bit bus.
package sobel_pkg;

    localparam int DWIDTH     = 8;
    localparam int WIN_SIZE   = 3;
    localparam int WIN_PIXELS = WIN_SIZE * WIN_SIZE;
    localparam int WIN_WIDTH  = WIN_PIXELS * DWIDTH;

    // Byte index of window element (r, c); r=0 is the top row, c=0 the left column.
    function automatic int win_idx(input int r, input int c);
        return r * WIN_SIZE + c;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixel storage: combinational read and write-enabled write
// at the same address, so a read-modify-write per pixel fits in one cycle.
module sobel_line_buffer #(
    parameter int IMG_WIDTH = 720,
    parameter int DWIDTH    = 8,
    parameter int AW        = $clog2(IMG_WIDTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [IMG_WIDTH];

    assign rdata = mem[addr];

    always_ff @(posedge clock) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/sobel_window.sv
// Raster pixel stream -> one packed 3x3 neighbourhood per accepted pixel,
// centred one row and one column behind the incoming pixel.
module sobel_window #(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int DWIDTH     = sobel_pkg::DWIDTH
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DWIDTH-1:0]                     in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [sobel_pkg::WIN_PIXELS*DWIDTH-1:0] out_window,
    output logic                                  out_last
);

    import sobel_pkg::*;

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              accept;
    logic              border;
    logic              last_pix;
    logic [DWIDTH-1:0] rd0;
    logic [DWIDTH-1:0] rd1;
    logic [DWIDTH-1:0] win     [WIN_SIZE][WIN_SIZE];
    logic [DWIDTH-1:0] win_nxt [WIN_SIZE][WIN_SIZE];
    logic [WIN_PIXELS*DWIDTH-1:0] packed_nxt;

    assign in_ready = !out_valid || out_ready;
    // Gated by reset so a held-in-reset source never writes the line buffers.
    assign accept   = in_valid && in_ready && reset;

    // lb0 holds row-1, lb1 holds row-2; lb1 is refilled from lb0's old value.
    sobel_line_buffer #(.IMG_WIDTH(IMG_WIDTH), .DWIDTH(DWIDTH), .AW(COL_W)) u_lb0 (
        .clock (clock),
        .we    (accept),
        .addr  (col),
        .wdata (in_data),
        .rdata (rd0)
    );

    sobel_line_buffer #(.IMG_WIDTH(IMG_WIDTH), .DWIDTH(DWIDTH), .AW(COL_W)) u_lb1 (
        .clock (clock),
        .we    (accept),
        .addr  (col),
        .wdata (rd0),
        .rdata (rd1)
    );

    always_comb begin
        for (int r = 0; r < WIN_SIZE; r++) begin
            win_nxt[r][0] = win[r][1];
            win_nxt[r][1] = win[r][2];
        end
        win_nxt[0][2] = rd1;
        win_nxt[1][2] = rd0;
        win_nxt[2][2] = in_data;
    end

    always_comb begin
        packed_nxt = '0;
        for (int r = 0; r < WIN_SIZE; r++) begin
            for (int c = 0; c < WIN_SIZE; c++) begin
                packed_nxt[win_idx(r, c)*DWIDTH +: DWIDTH] = win_nxt[r][c];
            end
        end
    end

    // Stale columns after a line wrap and stale rows from the prior frame sit
    // only in positions this mask zeroes.
    assign border   = (row < ROW_W'(2)) || (col < COL_W'(2));
    assign last_pix = (row == ROW_W'(IMG_HEIGHT-1)) && (col == COL_W'(IMG_WIDTH-1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_window <= '0;
            out_last   <= 1'b0;
            col        <= '0;
            row        <= '0;
            for (int r = 0; r < WIN_SIZE; r++) begin
                for (int c = 0; c < WIN_SIZE; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_window <= border ? '0 : packed_nxt;
            out_last   <= last_pix;
            win        <= win_nxt;
            if (col == COL_W'(IMG_WIDTH-1)) begin
                col <= '0;
                row <= (row == ROW_W'(IMG_HEIGHT-1)) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_window.sv
// Randomized bench for sobel_window on a 4x4 image against an image-array model
// that forms each expected window directly from pixel coordinates.
module tb_sobel_window;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [71:0]   out_window;
    logic          out_last;

    sobel_window #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_window (out_window),
        .out_last   (out_last)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [71:0] win;
        logic        last;
        int          r;
        int          c;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  img [H][W];
    int          mrow = 0;
    int          mcol = 0;
    int          nvec = 0;
    int          nerr = 0;
    int          nwin = 0;
    logic [71:0] win22;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [71:0] model_win(input int r0, input int c0);
        logic [71:0] w = '0;
        if (r0 >= 2 && c0 >= 2)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w[(r*3+c)*8 +: 8] = img[r0-2+r][c0-2+c];
        return w;
    endfunction

    // Monitor: transfers are checked against the queue, accepts feed the model.
    always @(negedge clock) begin
        if (!reset) begin
            q.delete();
            mrow = 0;
            mcol = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_window", 72'(1), 72'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk($sformatf("win(%0d,%0d)", e.r, e.c), out_window, e.win);
                    chk($sformatf("last(%0d,%0d)", e.r, e.c), 72'(out_last), 72'(e.last));
                    if (e.r == 2 && e.c == 2) win22 = out_window;
                    nwin++;
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                img[mrow][mcol] = in_data;
                e.win  = model_win(mrow, mcol);
                e.last = (mrow == H-1) && (mcol == W-1);
                e.r    = mrow;
                e.c    = mcol;
                q.push_back(e);
                if (mcol == W-1) begin
                    mcol = 0;
                    mrow = (mrow == H-1) ? 0 : mrow + 1;
                end else begin
                    mcol++;
                end
            end
        end
    end

    function automatic logic [7:0] pix(input int mode, input int r, input int c);
        case (mode)
            0:       return 8'(r*16 + c);
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    // Task time base: called and returns at posedge+1.
    task automatic run_frame(input int mode, input bit bubbles, input int stall_at,
                             input int abort_at, input bit rnd_ready);
        for (int i = 0; i < W*H; i++) begin
            int  n;
            bit  acc;
            if (i == abort_at) begin
                reset    = 1'b0;
                in_valid = 1'b1;
                @(posedge clock); #1;
                @(negedge clock);
                chk("abort_valid", 72'(out_valid), 72'(0));
                chk("abort_window", out_window, 72'(0));
                @(posedge clock); #1;
                reset    = 1'b1;
                in_valid = 1'b0;
                return;
            end
            if (bubbles) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(posedge clock); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = pix(mode, i / W, i % W);
            if (i == stall_at) begin
                logic [71:0] held;
                out_ready = 1'b0;
                held      = out_window;
                repeat (5) begin
                    @(negedge clock);
                    chk("stall_ready", 72'(in_ready), 72'(0));
                    chk("stall_hold", out_window, held);
                    @(posedge clock); #1;
                end
                out_ready = 1'b1;
            end
            n = 0;
            do begin
                if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
                @(negedge clock);
                acc = in_ready;
                @(posedge clock); #1;
                n++;
            end while (!acc && n < 50);
            if (!acc) chk("accept_timeout", 72'(0), 72'(1));
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        @(posedge clock); #1;
        chk("drain_queue", 72'(q.size()), 72'(0));
        chk("drain_valid", 72'(out_valid), 72'(0));
    endtask

    initial begin
        int base;

        // Reset held with in_valid high.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) begin
            @(posedge clock); #1;
            chk("rst_valid", 72'(out_valid), 72'(0));
            chk("rst_window", out_window, 72'(0));
            chk("rst_last", 72'(out_last), 72'(0));
        end
        reset    = 1'b1;
        in_valid = 1'b0;

        // Plain frame.
        base = nwin; win22 = '0;
        run_frame(0, 0, -1, -1, 0);
        drain();
        chk("f_plain_count", 72'(nwin - base), 72'(W*H));
        chk("f_plain_win22", win22, 72'h22_21_20_12_11_10_02_01_00);

        // Backpressure mid-line.
        base = nwin; win22 = '0;
        run_frame(0, 0, 6, -1, 0);
        drain();
        chk("f_stall_count", 72'(nwin - base), 72'(W*H));
        chk("f_stall_win22", win22, 72'h22_21_20_12_11_10_02_01_00);

        // Input bubbles.
        base = nwin; win22 = '0;
        run_frame(0, 1, -1, -1, 0);
        drain();
        chk("f_bubble_count", 72'(nwin - base), 72'(W*H));
        chk("f_bubble_win22", win22, 72'h22_21_20_12_11_10_02_01_00);

        // Back-to-back frames; second frame all 0xFF.
        base = nwin; win22 = '0;
        run_frame(0, 0, -1, -1, 0);
        run_frame(1, 0, -1, -1, 0);
        drain();
        chk("f_b2b_count", 72'(nwin - base), 72'(2*W*H));
        chk("f_b2b_win22", win22, {9{8'hFF}});

        // Reset at (1,3), then a full frame.
        run_frame(0, 0, -1, 7, 0);
        base = nwin; win22 = '0;
        run_frame(0, 0, -1, -1, 0);
        drain();
        chk("f_abort_count", 72'(nwin - base), 72'(W*H));
        chk("f_abort_win22", win22, 72'h22_21_20_12_11_10_02_01_00);

        // Random pixels, random bubbles and random output readiness.
        base = nwin;
        repeat (3) run_frame(2, 1, -1, -1, 1);
        drain();
        chk("f_rand_count", 72'(nwin - base), 72'(3*W*H));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1);
    end

endmodule
